// File: rtl/eth_bringup_seq_if.sv
// Signal bundle between the Ethernet bring-up sequencer and its surroundings.
// retrigger and rx_activity are single-cycle pulses sampled on every clk_200m edge; there is no back-pressure.
interface eth_bringup_seq_if;
  logic       idelayctrl_rdy;
  logic       retrigger;
  logic       rx_activity;
  logic       idelay_ctl_rst;
  logic       phy_rstn;
  logic       sys_ready;
  logic       led;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  modport master (
    input  idelayctrl_rdy, retrigger, rx_activity,
    output idelay_ctl_rst, phy_rstn, sys_ready, led, state, fault_cnt
  );

  modport slave (
    output idelayctrl_rdy, retrigger, rx_activity,
    input  idelay_ctl_rst, phy_rstn, sys_ready, led, state, fault_cnt
  );
endinterface

// File: rtl/eth_bringup_seq.sv
// Ethernet datapath bring-up: IDELAYCTRL reset, PHY reset, PHY settle, then sys_ready.
// Also drives a status LED (slow blink when ready, fast during bring-up, stretched on rx activity).
module eth_bringup_seq #(
  parameter int CNT_W           = 32,
  parameter int IDLY_RST_CYCLES = 16,
  parameter int IDLY_TIMEOUT    = 1024,
  parameter int PHY_RST_CYCLES  = 2_000_000,
  parameter int PHY_WAIT_CYCLES = 10_000_000,
  parameter int HB_HALF_PERIOD  = 100_000_000,
  parameter int ACT_CYCLES      = 10_000_000
) (
  input  logic              clk_200m,
  input  logic              rstn,
  eth_bringup_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLY_RST  = 3'd0,
    S_IDLY_WAIT = 3'd1,
    S_PHY_RST   = 3'd2,
    S_PHY_WAIT  = 3'd3,
    S_READY     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] IDLY_RST_LAST = CNT_W'(IDLY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLY_TMO_LAST = CNT_W'(IDLY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_RDY_LAST   = CNT_W'(HB_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HB_BOOT_LAST  = CNT_W'(HB_HALF_PERIOD / 4 - 1);
  localparam logic [CNT_W-1:0] ACT_LOAD      = CNT_W'(ACT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] led_cnt_q;
  logic [CNT_W-1:0] act_cnt_q;
  logic             blink_q;
  logic [7:0]       fault_q;
  logic             fault_inc;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] half_last;

  always_comb begin
    state_d   = state_q;
    fault_inc = 1'b0;
    case (state_q)
      S_IDLY_RST:  if (cnt_q == IDLY_RST_LAST) state_d = S_IDLY_WAIT;
      S_IDLY_WAIT: begin
        if (bus.idelayctrl_rdy) begin
          state_d = S_PHY_RST;
        end else if (cnt_q == IDLY_TMO_LAST) begin
          state_d   = S_IDLY_RST;
          fault_inc = 1'b1;
        end
      end
      S_PHY_RST:   if (cnt_q == PHY_RST_LAST) state_d = S_PHY_WAIT;
      S_PHY_WAIT, S_READY: begin
        // Losing IDELAYCTRL ready outranks a retrigger: the whole chain must restart.
        if (!bus.idelayctrl_rdy)
          state_d = S_IDLY_RST;
        else if (bus.retrigger)
          state_d = S_PHY_RST;
        else if (state_q == S_PHY_WAIT && cnt_q == PHY_WAIT_LAST)
          state_d = S_READY;
      end
      default:     state_d = S_IDLY_RST;
    endcase
  end

  assign ready_q   = (state_q == S_READY);
  assign ready_d   = (state_d == S_READY);
  assign half_last = ready_q ? HB_RDY_LAST : HB_BOOT_LAST;

  always_ff @(posedge clk_200m) begin
    if (!rstn) begin
      state_q   <= S_IDLY_RST;
      cnt_q     <= '0;
      led_cnt_q <= '0;
      act_cnt_q <= '0;
      blink_q   <= 1'b0;
      fault_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_ONE;

      if (fault_inc && fault_q != 8'hFF)
        fault_q <= fault_q + 8'd1;

      // The blink phase restarts whenever sys_ready flips so the new rate starts cleanly.
      if (ready_d != ready_q) begin
        led_cnt_q <= '0;
      end else if (led_cnt_q == half_last) begin
        led_cnt_q <= '0;
        blink_q   <= ~blink_q;
      end else begin
        led_cnt_q <= led_cnt_q + CNT_ONE;
      end

      if (ready_q && ready_d) begin
        if (bus.rx_activity)
          act_cnt_q <= ACT_LOAD;
        else if (act_cnt_q != '0)
          act_cnt_q <= act_cnt_q - CNT_ONE;
      end else begin
        act_cnt_q <= '0;
      end
    end
  end

  assign bus.idelay_ctl_rst = (state_q == S_IDLY_RST);
  assign bus.phy_rstn       = (state_q == S_PHY_WAIT) || (state_q == S_READY);
  assign bus.sys_ready      = ready_q;
  assign bus.led            = blink_q | (act_cnt_q != '0);
  assign bus.state          = state_q;
  assign bus.fault_cnt      = fault_q;

endmodule

// File: tb/tb_eth_bringup_seq.sv
// Bench for eth_bringup_seq: directed scenarios with literal timing checks, then random traffic,
// all compared every cycle against a phase/time-remaining model of the bring-up rules.
module tb_eth_bringup_seq;
  localparam int P_IDLY_RST = 4;
  localparam int P_IDLY_TMO = 20;
  localparam int P_PHY_RST  = 10;
  localparam int P_PHY_WAIT = 6;
  localparam int P_HB       = 8;
  localparam int P_ACT      = 5;

  logic clk_200m;
  logic rstn;
  eth_bringup_seq_if bus();

  eth_bringup_seq #(
    .CNT_W(32), .IDLY_RST_CYCLES(P_IDLY_RST), .IDLY_TIMEOUT(P_IDLY_TMO),
    .PHY_RST_CYCLES(P_PHY_RST), .PHY_WAIT_CYCLES(P_PHY_WAIT),
    .HB_HALF_PERIOD(P_HB), .ACT_CYCLES(P_ACT)
  ) dut (
    .clk_200m(clk_200m),
    .rstn(rstn),
    .bus(bus.master)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk_200m = 1'b0;
    forever #5 clk_200m = ~clk_200m;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase number plus cycles remaining in the timed phase; LED as elapsed time since last toggle.
  int m_ph, m_left, m_faults, m_elapsed, m_blink, m_act;
  bit m_valid = 1'b0;

  function automatic int phase_len(input int p);
    case (p)
      0:       return P_IDLY_RST;
      1:       return P_IDLY_TMO;
      2:       return P_PHY_RST;
      3:       return P_PHY_WAIT;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int nph;
    bit was_ready;
    m_valid = 1'b1;
    if (!rstn) begin
      m_ph = 0; m_left = P_IDLY_RST; m_faults = 0;
      m_elapsed = 0; m_blink = 0; m_act = 0;
    end else begin
      was_ready = (m_ph == 4);
      nph = m_ph;
      case (m_ph)
        0: begin m_left--; if (m_left == 0) nph = 1; end
        1: begin
          if (bus.idelayctrl_rdy) nph = 2;
          else begin
            m_left--;
            if (m_left == 0) begin nph = 0; if (m_faults < 255) m_faults++; end
          end
        end
        2: begin m_left--; if (m_left == 0) nph = 3; end
        default: begin
          if (!bus.idelayctrl_rdy) nph = 0;
          else if (bus.retrigger) nph = 2;
          else if (m_ph == 3) begin m_left--; if (m_left == 0) nph = 4; end
        end
      endcase
      if (nph != m_ph) m_left = phase_len(nph);
      if ((nph == 4) != was_ready) m_elapsed = 0;
      else begin
        m_elapsed++;
        if (m_elapsed == (was_ready ? P_HB : P_HB / 4)) begin
          m_blink = 1 - m_blink;
          m_elapsed = 0;
        end
      end
      if (m_ph == 4 && nph == 4) m_act = bus.rx_activity ? P_ACT : (m_act > 0 ? m_act - 1 : 0);
      else m_act = 0;
      m_ph = nph;
    end
  endtask

  initial forever begin
    @(posedge clk_200m);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_200m);
    if (m_valid) begin
      check("state",          bus.state,          m_ph);
      check("idelay_ctl_rst", bus.idelay_ctl_rst, (m_ph == 0) ? 1 : 0);
      check("phy_rstn",       bus.phy_rstn,       (m_ph >= 3) ? 1 : 0);
      check("sys_ready",      bus.sys_ready,      (m_ph == 4) ? 1 : 0);
      check("led",            bus.led,            ((m_blink != 0) || (m_act != 0)) ? 1 : 0);
      check("fault_cnt",      bus.fault_cnt,      m_faults);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_200m);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rstn = 1'b0;
    bus.idelayctrl_rdy = rdy;
    bus.retrigger = 1'b0;
    bus.rx_activity = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.state !== s && n < budget) begin tick(1); n++; end
    check("wait_state", bus.state, s);
  endtask

  task automatic measure_bringup(input bit retrig_early, output int k, output int rst_hi, output int phy_lo);
    k = 0; rst_hi = 0; phy_lo = 0;
    while (bus.sys_ready !== 1'b1 && k < 500) begin
      if (bus.idelay_ctl_rst) rst_hi++;
      if (!bus.phy_rstn) phy_lo++;
      bus.retrigger = retrig_early && (k == 1);
      tick(1);
      k++;
    end
    bus.retrigger = 1'b0;
  endtask

  task automatic led_interval(output int n);
    logic l0;
    int g = 0;
    l0 = bus.led;
    while (bus.led === l0 && g < 50) begin tick(1); g++; end
    l0 = bus.led;
    n = 0;
    while (bus.led === l0 && n < 50) begin tick(1); n++; end
  endtask

  task automatic wait_led_fall();
    int g = 0;
    while (bus.led !== 1'b1 && g < 50) begin tick(1); g++; end
    while (bus.led !== 1'b0 && g < 100) begin tick(1); g++; end
    check("led_fall_found", (g < 100) ? 1 : 0, 1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int k, hi, lo, n;
    rstn = 1'b0;
    bus.idelayctrl_rdy = 1'b1;
    bus.retrigger = 1'b0;
    bus.rx_activity = 1'b0;

    // Nominal bring-up timing
    do_reset(1'b1);
    check("reset_state", bus.state, 0);
    check("reset_led", bus.led, 0);
    measure_bringup(1'b0, k, hi, lo);
    check("ready_latency", k, 21);
    check("idelay_rst_len", hi, 4);
    check("phy_rst_len", lo, 15);

    // retrigger during IDELAYCTRL reset is ignored
    do_reset(1'b1);
    measure_bringup(1'b1, k, hi, lo);
    check("ready_latency_retrig0", k, 21);

    // retrigger in ready
    bus.retrigger = 1'b1;
    tick(1);
    bus.retrigger = 1'b0;
    check("retrig_drop_ready", bus.sys_ready, 0);
    n = 0;
    while (bus.phy_rstn !== 1'b1 && n < 100) begin n++; tick(1); end
    check("retrig_phy_low", n, 10);
    n = 0;
    while (bus.sys_ready !== 1'b1 && n < 100) begin n++; tick(1); end
    check("retrig_settle", n, 6);

    // idelayctrl_rdy loss in ready, alone and together with retrigger
    bus.idelayctrl_rdy = 1'b0;
    tick(1);
    check("rdy_drop_state", bus.state, 0);
    check("rdy_drop_idly_rst", bus.idelay_ctl_rst, 1);
    bus.idelayctrl_rdy = 1'b1;
    wait_state(3'd4, 100);
    bus.idelayctrl_rdy = 1'b0;
    bus.retrigger = 1'b1;
    tick(1);
    bus.retrigger = 1'b0;
    bus.idelayctrl_rdy = 1'b1;
    check("rdy_drop_beats_retrig", bus.state, 0);

    // LED: fast blink before ready (activity ignored), slow blink in ready, activity stretch
    do_reset(1'b1);
    tick(1);
    bus.rx_activity = 1'b1;
    tick(1);
    bus.rx_activity = 1'b0;
    led_interval(n);
    check("led_boot_half", n, 2);
    wait_state(3'd4, 100);
    led_interval(n);
    check("led_ready_half", n, 8);
    wait_led_fall();
    bus.rx_activity = 1'b1;
    tick(1);
    bus.rx_activity = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin if (bus.led) hi++; tick(1); end
    check("act_stretch_single", hi, 5);
    wait_led_fall();
    bus.rx_activity = 1'b1;
    tick(1);
    bus.rx_activity = 1'b0;
    hi = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.led) hi++;
      bus.rx_activity = (i == 2);
      tick(1);
    end
    bus.rx_activity = 1'b0;
    check("act_stretch_double", hi, 7);

    // IDELAYCTRL timeouts
    do_reset(1'b0);
    tick(50);
    check("fault_cnt_two", bus.fault_cnt, 2);
    bus.idelayctrl_rdy = 1'b1;
    wait_state(3'd4, 100);

    // fault counter saturation
    do_reset(1'b0);
    tick(256 * (P_IDLY_RST + P_IDLY_TMO) + 10);
    check("fault_cnt_sat", bus.fault_cnt, 255);
    bus.idelayctrl_rdy = 1'b1;
    wait_state(3'd4, 100);

    // Mid-sequence reset from PHY settle
    wait_state(3'd4, 10);
    bus.retrigger = 1'b1;
    tick(1);
    bus.retrigger = 1'b0;
    wait_state(3'd3, 50);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_idly", bus.idelay_ctl_rst, 1);
    check("mid_rst_phy", bus.phy_rstn, 0);
    check("mid_rst_ready", bus.sys_ready, 0);
    check("mid_rst_led", bus.led, 0);
    check("mid_rst_fault", bus.fault_cnt, 0);
    measure_bringup(1'b0, k, hi, lo);
    check("mid_rst_relatency", k, 21);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.retrigger   = ($urandom_range(0, 49) == 0);
      bus.rx_activity = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) bus.idelayctrl_rdy = ~bus.idelayctrl_rdy;
      rstn = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rstn = 1'b1;
    bus.retrigger = 1'b0;
    bus.rx_activity = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
